// File: rtl/riscv_checkpoint_monitor.sv
// Compares the core observation port against a table of expected values at programmed
// retired-instruction counts and reports pass/fail, first-failure details and run length.
module riscv_checkpoint_monitor #(
  parameter int          DWIDTH  = 32,
  parameter int          NUM_CHK = 40,
  parameter int unsigned TIMEOUT = 32'd1000000,
  localparam int         IWIDTH  = $clog2(NUM_CHK)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_WE,
  input  logic [IWIDTH-1:0] CFG_IDX,
  input  logic [DWIDTH-1:0] CFG_NUM_INST,
  input  logic [DWIDTH-1:0] CFG_ANS,
  input  logic [DWIDTH-1:0] CFG_MASK,
  input  logic [IWIDTH:0]   CFG_COUNT,
  input  logic              STOP_ON_FAIL,
  input  logic              START,
  input  logic [DWIDTH-1:0] NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic              TIMED_OUT,
  output logic [IWIDTH:0]   PASS_CNT,
  output logic [IWIDTH:0]   FAIL_CNT,
  output logic [IWIDTH-1:0] FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_VALUE,
  output logic [DWIDTH-1:0] CYCLE_CNT
);

  localparam int CW = IWIDTH + 1;
  localparam logic [DWIDTH-1:0] TMO = DWIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     ptr, ptr_n, count_q, count_n;
  logic [CW-1:0]     pass_q, pass_n, fail_q, fail_n;
  logic [IWIDTH-1:0] fidx_q, fidx_n;
  logic [DWIDTH-1:0] fval_q, fval_n, cyc_q, cyc_n;
  logic              tmo_q, tmo_n, sof_q, sof_n;
  logic              wr_en, missed;
  logic [IWIDTH-1:0] ptr_idx;

  // Table is not reset; it must be reloaded after RST.
  logic [DWIDTH-1:0] tbl_num  [NUM_CHK];
  logic [DWIDTH-1:0] tbl_ans  [NUM_CHK];
  logic [DWIDTH-1:0] tbl_mask [NUM_CHK];

  assign ptr_idx = ptr[IWIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tbl_num[CFG_IDX]  <= CFG_NUM_INST;
      tbl_ans[CFG_IDX]  <= CFG_ANS;
      tbl_mask[CFG_IDX] <= CFG_MASK;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= '0;
      count_q <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      fidx_q  <= '0;
      fval_q  <= '0;
      cyc_q   <= '0;
      tmo_q   <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      count_q <= count_n;
      pass_q  <= pass_n;
      fail_q  <= fail_n;
      fidx_q  <= fidx_n;
      fval_q  <= fval_n;
      cyc_q   <= cyc_n;
      tmo_q   <= tmo_n;
      sof_q   <= sof_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    count_n = count_q;
    pass_n  = pass_q;
    fail_n  = fail_q;
    fidx_n  = fidx_q;
    fval_n  = fval_q;
    cyc_n   = cyc_q;
    tmo_n   = tmo_q;
    sof_n   = sof_q;
    wr_en   = 1'b0;
    missed  = 1'b0;
    case (state)
      IDLE, FIN: begin
        wr_en = CFG_WE && (int'(CFG_IDX) < NUM_CHK);
        if (START) begin
          state_n = RUN;
          ptr_n   = '0;
          pass_n  = '0;
          fail_n  = '0;
          fidx_n  = '0;
          fval_n  = '0;
          cyc_n   = '0;
          tmo_n   = 1'b0;
          sof_n   = STOP_ON_FAIL;
          count_n = (int'(CFG_COUNT) > NUM_CHK) ? CW'(NUM_CHK) : CFG_COUNT;
        end
      end
      RUN: begin
        if (cyc_q != '1) cyc_n = cyc_q + 1'b1;
        // A count beyond the entry's checkpoint means the core skipped it.
        if (ptr < count_q) begin
          if (NUM_INST == tbl_num[ptr_idx]) begin
            ptr_n = ptr + 1'b1;
            if (((OUTPUT_PORT ^ tbl_ans[ptr_idx]) & tbl_mask[ptr_idx]) == '0)
              pass_n = pass_q + 1'b1;
            else
              missed = 1'b1;
          end else if (NUM_INST > tbl_num[ptr_idx]) begin
            ptr_n  = ptr + 1'b1;
            missed = 1'b1;
          end
        end
        if (missed) begin
          fail_n = fail_q + 1'b1;
          if (fail_q == '0) begin
            fidx_n = ptr_idx;
            fval_n = OUTPUT_PORT;
          end
        end
        if ((missed && sof_q) || (ptr_n == count_q && fail_n == '0)) begin
          state_n = FIN;
        end else if (HALT) begin
          state_n = FIN;
          if (ptr_n < count_q) begin
            if (fail_n == '0) begin
              fidx_n = ptr_n[IWIDTH-1:0];
              fval_n = OUTPUT_PORT;
            end
            fail_n = fail_n + (count_q - ptr_n);
          end
        end else if (cyc_n >= TMO) begin
          state_n = FIN;
          tmo_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign BUSY       = (state == RUN);
  assign DONE       = (state == FIN);
  assign PASS       = (state == FIN) && (fail_q == '0) && !tmo_q;
  assign TIMED_OUT  = tmo_q;
  assign PASS_CNT   = pass_q;
  assign FAIL_CNT   = fail_q;
  assign FAIL_IDX   = fidx_q;
  assign FAIL_VALUE = fval_q;
  assign CYCLE_CNT  = cyc_q;

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// Bench for riscv_checkpoint_monitor: directed runs checked every cycle against a
// queue-based model of the checkpoint list, plus hand-computed end-of-run values.
module tb_riscv_checkpoint_monitor;

  localparam int DW  = 32;
  localparam int NCH = 40;
  localparam int IW  = $clog2(NCH);
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CFG_WE = 1'b0;
  logic [IW-1:0] CFG_IDX = '0;
  logic [DW-1:0] CFG_NUM_INST = '0, CFG_ANS = '0, CFG_MASK = '0;
  logic [IW:0]   CFG_COUNT = '0;
  logic          STOP_ON_FAIL = 1'b0, START = 1'b0, HALT = 1'b0;
  logic [DW-1:0] NUM_INST = '0, OUTPUT_PORT = '0;
  logic          BUSY, DONE, PASS, TIMED_OUT;
  logic [IW:0]   PASS_CNT, FAIL_CNT;
  logic [IW-1:0] FAIL_IDX;
  logic [DW-1:0] FAIL_VALUE, CYCLE_CNT;

  riscv_checkpoint_monitor #(.DWIDTH(DW), .NUM_CHK(NCH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
    .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_MASK(CFG_MASK),
    .CFG_COUNT(CFG_COUNT), .STOP_ON_FAIL(STOP_ON_FAIL), .START(START),
    .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMED_OUT(TIMED_OUT),
    .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .FAIL_IDX(FAIL_IDX),
    .FAIL_VALUE(FAIL_VALUE), .CYCLE_CNT(CYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] t_num [NCH];
  logic [DW-1:0] t_ans [NCH];
  logic [DW-1:0] t_mask[NCH];
  int            pend[$];
  bit            m_run = 0, m_done = 0, m_tmo = 0, m_sof = 0, m_miss = 0;
  int            m_pass = 0, m_fail = 0, m_fidx = 0, m_k = 0;
  logic [DW-1:0] m_fval = '0, m_cyc = '0;

  task automatic note_fail(input int k);
    if (m_fail == 0) begin
      m_fidx = k;
      m_fval = OUTPUT_PORT;
    end
    m_fail++;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_run = 0; m_done = 0; m_tmo = 0; m_pass = 0; m_fail = 0;
      m_fidx = 0; m_fval = '0; m_cyc = '0;
      pend.delete();
    end else if (!m_run) begin
      if (CFG_WE && int'(CFG_IDX) < NCH) begin
        t_num[CFG_IDX] = CFG_NUM_INST;
        t_ans[CFG_IDX] = CFG_ANS;
        t_mask[CFG_IDX] = CFG_MASK;
      end
      if (START) begin
        m_run = 1; m_done = 0; m_tmo = 0; m_pass = 0; m_fail = 0;
        m_fidx = 0; m_fval = '0; m_cyc = '0; m_sof = STOP_ON_FAIL;
        pend.delete();
        for (int i = 0; i < NCH && i < int'(CFG_COUNT); i++) pend.push_back(i);
      end
    end else begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      m_miss = 0;
      if (pend.size() > 0 && NUM_INST >= t_num[pend[0]]) begin
        m_k = pend.pop_front();
        if (NUM_INST == t_num[m_k] && (OUTPUT_PORT & t_mask[m_k]) == (t_ans[m_k] & t_mask[m_k]))
          m_pass++;
        else begin
          m_miss = 1;
          note_fail(m_k);
        end
      end
      if ((m_miss && m_sof) || (pend.size() == 0 && m_fail == 0)) begin
        m_run = 0; m_done = 1;
      end else if (HALT) begin
        while (pend.size() > 0) note_fail(pend.pop_front());
        m_run = 0; m_done = 1;
      end else if (m_cyc >= TMO) begin
        m_run = 0; m_done = 1; m_tmo = 1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("BUSY", 32'(BUSY), 32'(m_run));
    chk("DONE", 32'(DONE), 32'(m_done));
    chk("PASS", 32'(PASS), 32'(m_done && m_fail == 0 && !m_tmo));
    chk("TIMED_OUT", 32'(TIMED_OUT), 32'(m_tmo));
    chk("PASS_CNT", 32'(PASS_CNT), m_pass);
    chk("FAIL_CNT", 32'(FAIL_CNT), m_fail);
    chk("FAIL_IDX", 32'(FAIL_IDX), m_fidx);
    chk("FAIL_VALUE", FAIL_VALUE, m_fval);
    chk("CYCLE_CNT", CYCLE_CNT, m_cyc);
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] ni;
    logic [31:0] op;
    logic        h;
    logic        st;
    logic        we;
  } step_t;
  step_t steps[$];
  logic [31:0] p4 = 32'h0F00;

  function automatic logic [31:0] port_for(input int n);
    case (n)
      4: return p4;
      6: return 32'h18;
      8: return 32'h1D;
      default: return 32'hDEAD;
    endcase
  endfunction

  task automatic push(input logic [31:0] ni, input logic [31:0] op, input logic h,
                      input logic st, input logic we);
    step_t s;
    s.ni = ni; s.op = op; s.h = h; s.st = st; s.we = we;
    steps.push_back(s);
  endtask

  // Pushes NUM_INST = lo..hi; HALT on halt_at; port bad_v at bad_n.
  task automatic lin(input int lo, input int hi, input int halt_at, input int bad_n,
                     input logic [31:0] bad_v);
    for (int n = lo; n <= hi; n++)
      push(n, (n == bad_n) ? bad_v : port_for(n), n == halt_at, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] num, input logic [31:0] ans,
                    input logic [31:0] mask);
    CFG_IDX = IW'(idx); CFG_NUM_INST = num; CFG_ANS = ans; CFG_MASK = mask; CFG_WE = 1'b1;
    tick();
    CFG_WE = 1'b0;
  endtask

  // Arms the monitor, then plays the queued steps until DONE or the queue runs out.
  task automatic run(input logic sof, input int cnt);
    STOP_ON_FAIL = sof; CFG_COUNT = (IW+1)'(cnt); NUM_INST = '0; START = 1'b1;
    tick();
    START = 1'b0;
    foreach (steps[i]) begin
      NUM_INST = steps[i].ni; OUTPUT_PORT = steps[i].op; HALT = steps[i].h;
      START = steps[i].st; CFG_WE = steps[i].we;
      tick();
      if (DONE) break;
    end
    START = 1'b0; HALT = 1'b0; CFG_WE = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0;
    steps.delete();
  endtask

  initial begin
    #1;
    tick();
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_cycle", CYCLE_CNT, 0);
    RST = 1'b0;
    tick();

    wr(0, 4, 32'h0F00, 32'hFFFF_FFFF);
    wr(1, 6, 32'h18, 32'hFFFF_FFFF);
    wr(2, 8, 32'h1D, 32'hFFFF_FFFF);

    // all three checkpoints match
    lin(1, 10, 10, -1, 0);
    run(1'b0, 3);
    chk("s1_done", 32'(DONE), 1);
    chk("s1_pass", 32'(PASS), 1);
    chk("s1_pass_cnt", 32'(PASS_CNT), 3);
    chk("s1_cycle", CYCLE_CNT, 8);

    // stop on first failure
    lin(1, 10, 10, 6, 32'h19);
    run(1'b1, 3);
    chk("s2_done", 32'(DONE), 1);
    chk("s2_fail_idx", 32'(FAIL_IDX), 1);
    chk("s2_fail_value", FAIL_VALUE, 32'h19);
    chk("s2_pass_cnt", 32'(PASS_CNT), 1);
    chk("s2_cycle", CYCLE_CNT, 6);

    // continue after failure, ended by HALT
    lin(1, 10, 10, 6, 32'h19);
    run(1'b0, 3);
    chk("s3_fail_cnt", 32'(FAIL_CNT), 1);
    chk("s3_pass_cnt", 32'(PASS_CNT), 2);
    chk("s3_pass", 32'(PASS), 0);
    chk("s3_cycle", CYCLE_CNT, 10);

    // skipped checkpoints
    lin(1, 5, -1, -1, 0);
    push(9, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    push(9, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    push(9, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    run(1'b0, 3);
    chk("s4_fail_cnt", 32'(FAIL_CNT), 2);
    chk("s4_fail_idx", 32'(FAIL_IDX), 1);
    chk("s4_pass_cnt", 32'(PASS_CNT), 1);

    // masked compare, HALT with two entries unchecked
    wr(0, 4, 32'h12, 32'h0000_00FF);
    p4 = 32'hAB12;
    lin(1, 5, 5, -1, 0);
    run(1'b0, 3);
    chk("s5_pass_cnt", 32'(PASS_CNT), 1);
    chk("s5_fail_cnt", 32'(FAIL_CNT), 2);
    chk("s5_fail_idx", 32'(FAIL_IDX), 1);

    // CFG_WE and START during RUN are ignored
    CFG_IDX = 1; CFG_NUM_INST = 2; CFG_ANS = 0; CFG_MASK = 32'hFFFF_FFFF;
    push(1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
    push(2, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    push(3, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    push(4, p4, 1'b0, 1'b0, 1'b0);
    push(5, 32'hDEAD, 1'b0, 1'b1, 1'b0);
    lin(6, 8, -1, -1, 0);
    run(1'b0, 3);
    chk("s6_pass", 32'(PASS), 1);
    chk("s6_pass_cnt", 32'(PASS_CNT), 3);
    chk("s6_cycle", CYCLE_CNT, 8);

    // timeout
    for (int i = 0; i < 20; i++) push(1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    run(1'b0, 3);
    chk("s7_done", 32'(DONE), 1);
    chk("s7_timed_out", 32'(TIMED_OUT), 1);
    chk("s7_cycle", CYCLE_CNT, 16);
    chk("s7_pass", 32'(PASS), 0);

    // reset in the middle of a run
    for (int i = 0; i < 3; i++) push(1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    run(1'b0, 3);
    chk("s8_busy", 32'(BUSY), 1);
    chk("s8_cycle", CYCLE_CNT, 3);
    RST = 1'b1;
    #1;
    chk("s8_rst_busy", 32'(BUSY), 0);
    chk("s8_rst_done", 32'(DONE), 0);
    chk("s8_rst_cycle", CYCLE_CNT, 0);
    chk("s8_rst_timed_out", 32'(TIMED_OUT), 0);
    tick();
    RST = 1'b0;
    tick();
    tick();
    chk("s8_idle_done", 32'(DONE), 0);

    // zero active entries passes on the first RUN cycle
    push(1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    run(1'b0, 0);
    chk("s9_done", 32'(DONE), 1);
    chk("s9_pass", 32'(PASS), 1);
    chk("s9_cycle", CYCLE_CNT, 1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_checkpoint_monitor.md
RISCV_CHECKPOINT_MONITOR -- requirements
Module: riscv_checkpoint_monitor

Interface
REQ-001 Parameter DWIDTH, 32, width of instruction-count, output-port and answer fields.
REQ-002 Parameter NUM_CHK, 40, number of checkpoint table entries; IWIDTH = clog2(NUM_CHK).
REQ-003 Parameter TIMEOUT, 32'd1000000, RUN-state cycle limit.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 CLK  in  1  clock, all state on rising edge.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 CFG_WE  in  1  write checkpoint entry CFG_IDX.
REQ-008 CFG_IDX  in  IWIDTH  entry index.
REQ-009 CFG_NUM_INST  in  DWIDTH  instruction count at which the entry is checked.
REQ-010 CFG_ANS  in  DWIDTH  expected OUTPUT_PORT value.
REQ-011 CFG_MASK  in  DWIDTH  compare mask; only bits set to 1 are compared.
REQ-012 CFG_COUNT  in  IWIDTH+1  number of active entries, sampled on START.
REQ-013 STOP_ON_FAIL  in  1  mode: 1 = end on first failure, 0 = continue; sampled on START.
REQ-014 START  in  1  single-cycle arm pulse.
REQ-015 NUM_INST  in  DWIDTH  core retired-instruction count, non-decreasing.
REQ-016 OUTPUT_PORT  in  DWIDTH  core observation port.
REQ-017 HALT  in  1  core halt indication.
REQ-018 BUSY  out  1  high in RUN.
REQ-019 DONE  out  1  high in DONE.
REQ-020 PASS  out  1  valid with DONE: all active entries matched, no timeout.
REQ-021 TIMED_OUT  out  1  valid with DONE: ended by TIMEOUT.
REQ-022 PASS_CNT, FAIL_CNT  out  IWIDTH+1 each  matched / failed entry counts.
REQ-023 FAIL_IDX  out  IWIDTH  index of first failed entry.
REQ-024 FAIL_VALUE  out  DWIDTH  OUTPUT_PORT captured at first failure.
REQ-025 CYCLE_CNT  out  DWIDTH  cycles spent in RUN.

Function
REQ-026 States IDLE, RUN, DONE; IDLE->RUN on START; RUN->DONE on end condition; DONE->RUN on START; START in RUN ignored.
REQ-027 CFG_WE honoured in IDLE and DONE only; ignored in RUN and when CFG_IDX >= NUM_CHK.
REQ-028 On START: PTR, PASS_CNT, FAIL_CNT, CYCLE_CNT, FAIL_IDX, FAIL_VALUE, TIMED_OUT cleared; CFG_COUNT clamped to NUM_CHK.
REQ-029 Entries checked in index order via PTR; one compare per entry regardless of how many cycles NUM_INST holds the value.
REQ-030 In RUN, PTR < count, NUM_INST == entry[PTR].num_inst: match if (OUTPUT_PORT & mask) == (ans & mask); PASS_CNT+1, PTR+1.
REQ-031 Mismatch: FAIL_CNT+1, PTR+1; first failure captures FAIL_IDX=PTR, FAIL_VALUE=OUTPUT_PORT; STOP_ON_FAIL=1 -> DONE next edge.
REQ-032 NUM_INST > entry[PTR].num_inst (checkpoint skipped): treated as mismatch, one entry per cycle.
REQ-033 Counter/flag updates visible one cycle after the sampling edge.
REQ-034 PTR reaching count with FAIL_CNT==0 -> DONE, PASS=1 (count 0 -> DONE, PASS=1 on cycle after START).
REQ-035 HALT in RUN -> DONE; unchecked entries (PTR < count) each add to FAIL_CNT, FAIL_IDX=PTR if no earlier failure.
REQ-036 CYCLE_CNT increments each RUN cycle, saturating; reaching TIMEOUT -> DONE, TIMED_OUT=1, PASS=0.
REQ-037 Same-cycle priority: checkpoint evaluation first, then HALT, then timeout; end conditions use post-evaluation counts.
REQ-038 PASS = (FAIL_CNT==0) & ~TIMED_OUT; outputs hold in DONE until START or RST.

Reset
REQ-039 RST asserted: state IDLE, all outputs 0, PTR 0; table contents undefined, must be reloaded.
REQ-040 RST mid-RUN aborts immediately; no DONE pulse.

Verification
REQ-041 Load 3 entries (4->0x0F00, 6->0x18, 8->0x1D, mask all-ones), START, drive matching values, HALT at 10 -> DONE, PASS=1, PASS_CNT=3.
REQ-042 Entry 1 expects 0x18, drive 0x19, STOP_ON_FAIL=1 -> DONE next cycle, FAIL_IDX=1, FAIL_VALUE=0x19, PASS_CNT=1.
REQ-043 Same with STOP_ON_FAIL=0 -> run continues, end FAIL_CNT=1, PASS_CNT=2, PASS=0.
REQ-044 NUM_INST jumps 5->9 past entries 6 and 8, then HALT -> FAIL_CNT=2, FAIL_IDX=1.
REQ-045 Mask 0x000000FF, ans 0x12, port 0xAB12 -> match; HALT with PTR=1 of 3 -> FAIL_CNT=2.
REQ-046 TIMEOUT=16, no HALT -> DONE after 16 RUN cycles, TIMED_OUT=1, CYCLE_CNT=16; RST mid-RUN -> all outputs 0.
